egg_timer_datapath: RTL and testbench

- Datapath and display end of the egg-timer controller interface. Consumes the 3-bit controller state code, the switch value and a clock.
- Holds the MM:SS count in BCD and loads it from the switches. Counts down at 1 Hz, drives four active-low seven-segment digits and the flash LEDs, and reports `done` when the count reaches 00:00.

---
 rtl/egg_timer_pkg.sv | 54 +++++
 rtl/egg_timer_datapath_seg7_decoder.sv | 27 ++
 rtl/egg_timer_datapath.sv | 124 ++++++++++++
 tb/tb_egg_timer_datapath.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/egg_timer_pkg.sv
// Shared definitions for the egg-timer controller and datapath: state codes,
// BCD digit types and the small BCD helpers used by the count register.
package egg_timer_pkg;

    localparam int BCD_W = 4;

    localparam logic [2:0] ST_SET_SEC     = 3'd0;
    localparam logic [2:0] ST_SET_MIN     = 3'd1;
    localparam logic [2:0] ST_TIMER       = 3'd2;
    localparam logic [2:0] ST_READY       = 3'd3;
    localparam logic [2:0] ST_RESET       = 3'd4;
    localparam logic [2:0] ST_FLASH_ON    = 3'd5;
    localparam logic [2:0] ST_FLASH_OFF   = 3'd6;
    localparam logic [2:0] ST_SETTING_MIN = 3'd7;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t min_t;
        bcd_t min_o;
        bcd_t sec_t;
        bcd_t sec_o;
    } count_t;

    function automatic bcd_t bcd_clamp(input bcd_t v, input bcd_t max_v);
        return (v > max_v) ? max_v : v;
    endfunction

    // One-second BCD decrement of MM:SS; caller guarantees the count is non-zero.
    function automatic count_t bcd_dec(input count_t c);
        count_t r;
        r = c;
        if (c.sec_o != 4'd0) begin
            r.sec_o = c.sec_o - 4'd1;
        end else begin
            r.sec_o = 4'd9;
            if (c.sec_t != 4'd0) begin
                r.sec_t = c.sec_t - 4'd1;
            end else begin
                r.sec_t = 4'd5;
                if (c.min_o != 4'd0) begin
                    r.min_o = c.min_o - 4'd1;
                end else begin
                    r.min_o = 4'd9;
                    r.min_t = c.min_t - 4'd1;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/egg_timer_datapath_seg7_decoder.sv
// BCD to active-low seven-segment decoder, segment order {g,f,e,d,c,b,a}.
// Non-decimal codes 10-15 light nothing.
module seg7_decoder
    import egg_timer_pkg::*;
(
    input  logic [BCD_W-1:0] bcd_i,
    output logic [6:0]       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0: seg_o = 7'b1000000;
            4'd1: seg_o = 7'b1111001;
            4'd2: seg_o = 7'b0100100;
            4'd3: seg_o = 7'b0110000;
            4'd4: seg_o = 7'b0011001;
            4'd5: seg_o = 7'b0010010;
            4'd6: seg_o = 7'b0000010;
            4'd7: seg_o = 7'b1111000;
            4'd8: seg_o = 7'b0000000;
            4'd9: seg_o = 7'b0010000;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/egg_timer_datapath.sv
// Egg-timer datapath: BCD MM:SS count loaded from the switches, 1 Hz countdown
// driven by the controller state code, seven-segment display and flash LEDs.
module egg_timer_datapath
    import egg_timer_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int LED_W  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       state,
    input  logic [7:0]       sw,
    output logic [6:0]       hex0,
    output logic [6:0]       hex1,
    output logic [6:0]       hex2,
    output logic [6:0]       hex3,
    output logic [LED_W-1:0] ledr,
    output logic             done
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

    count_t           count_q, count_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             done_q, done_d;
    logic [LED_W-1:0] ledr_q, ledr_d;
    logic             blank_q, blank_d;

    logic tick;
    logic count_zero;
    count_t count_dec;

    assign tick       = (presc_q == PRESC_MAX);
    assign count_zero = (count_q == '0);
    assign count_dec  = bcd_dec(count_q);

    always_comb begin
        count_d = count_q;
        presc_d = presc_q;
        done_d  = done_q;
        ledr_d  = (state == ST_FLASH_ON) ? {LED_W{1'b1}} : '0;
        blank_d = (state == ST_FLASH_OFF);
        case (state)
            ST_RESET: begin
                count_d = '0;
                presc_d = '0;
                done_d  = 1'b0;
            end
            ST_SET_SEC: begin
                count_d.sec_t = bcd_clamp(sw[7:4], 4'd5);
                count_d.sec_o = bcd_clamp(sw[3:0], 4'd9);
                presc_d       = '0;
                done_d        = 1'b0;
            end
            ST_SETTING_MIN, ST_SET_MIN: begin
                count_d.min_t = bcd_clamp(sw[7:4], 4'd9);
                count_d.min_o = bcd_clamp(sw[3:0], 4'd9);
                presc_d       = '0;
                done_d        = 1'b0;
            end
            ST_READY: begin
                presc_d = '0;
            end
            ST_TIMER: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                // An expired count sits at 00:00; the final decrement flags done on the same edge.
                if (count_zero) begin
                    done_d = 1'b1;
                end else if (tick) begin
                    count_d = count_dec;
                    if (count_dec == '0) begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_FLASH_ON, ST_FLASH_OFF: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            presc_q <= '0;
            done_q  <= 1'b0;
            ledr_q  <= '0;
            blank_q <= 1'b0;
        end else begin
            count_q <= count_d;
            presc_q <= presc_d;
            done_q  <= done_d;
            ledr_q  <= ledr_d;
            blank_q <= blank_d;
        end
    end

    bcd_t       digit_arr [4];
    logic [6:0] seg_arr   [4];
    logic [6:0] hex_arr   [4];

    assign digit_arr[0] = count_q.sec_o;
    assign digit_arr[1] = count_q.sec_t;
    assign digit_arr[2] = count_q.min_o;
    assign digit_arr[3] = count_q.min_t;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_digit
            seg7_decoder u_dec (
                .bcd_i (digit_arr[gi]),
                .seg_o (seg_arr[gi])
            );
            assign hex_arr[gi] = blank_q ? SEG_BLANK : seg_arr[gi];
        end
    endgenerate

    assign hex0 = hex_arr[0];
    assign hex1 = hex_arr[1];
    assign hex2 = hex_arr[2];
    assign hex3 = hex_arr[3];
    assign ledr = ledr_q;
    assign done = done_q;

endmodule

// File: tb/tb_egg_timer_datapath.sv
// Self-checking bench for egg_timer_datapath: a seconds-based behavioural model
// checked every cycle, plus directed literal display expectations.
module tb_egg_timer_datapath;

    localparam int CLK_HZ = 4;
    localparam int LED_W  = 10;

    localparam logic [2:0] S_SET_SEC = 3'd0, S_SET_MIN = 3'd1, S_TIMER = 3'd2,
                           S_READY = 3'd3, S_RESET = 3'd4, S_FON = 3'd5,
                           S_FOFF = 3'd6, S_SETTING_MIN = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       state;
    logic [7:0]       sw;
    logic [6:0]       hex0, hex1, hex2, hex3;
    logic [LED_W-1:0] ledr;
    logic             done;

    int n_pass  = 0;
    int n_total = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    egg_timer_datapath #(.CLK_HZ(CLK_HZ), .LED_W(LED_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .state (state),
        .sw    (sw),
        .hex0  (hex0),
        .hex1  (hex1),
        .hex2  (hex2),
        .hex3  (hex3),
        .ledr  (ledr),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endfunction

    // Model: count held as total seconds, elapsed cycles since last tick.
    int m_total = 0;
    int m_elapsed = 0;
    bit m_done = 0, m_led = 0, m_blank = 0, m_valid = 0;

    function automatic int clampi(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    always @(posedge clk) begin
        m_valid = 1;
        if (!rst_n) begin
            m_total = 0; m_elapsed = 0; m_done = 0; m_led = 0; m_blank = 0;
        end else begin
            m_led   = (state == S_FON);
            m_blank = (state == S_FOFF);
            case (state)
                S_RESET: begin m_total = 0; m_elapsed = 0; m_done = 0; end
                S_SET_SEC: begin
                    m_total = (m_total / 60) * 60 + clampi(int'(sw[7:4]), 5) * 10
                              + clampi(int'(sw[3:0]), 9);
                    m_elapsed = 0; m_done = 0;
                end
                S_SET_MIN, S_SETTING_MIN: begin
                    m_total = (clampi(int'(sw[7:4]), 9) * 10 + clampi(int'(sw[3:0]), 9)) * 60
                              + m_total % 60;
                    m_elapsed = 0; m_done = 0;
                end
                S_READY: m_elapsed = 0;
                S_TIMER: begin
                    bit tk;
                    m_elapsed++;
                    tk = (m_elapsed == CLK_HZ);
                    if (tk) m_elapsed = 0;
                    if (m_total == 0) m_done = 1;
                    else if (tk) begin
                        m_total--;
                        if (m_total == 0) m_done = 1;
                    end
                end
                default: ;
            endcase
        end
    end

    function automatic int exp_hex(input int pos);
        int mins, secs, d;
        mins = m_total / 60;
        secs = m_total % 60;
        case (pos)
            0: d = secs % 10;
            1: d = secs / 10;
            2: d = mins % 10;
            default: d = mins / 10;
        endcase
        return m_blank ? 7'h7F : int'(seg_tab[d]);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_hex0", int'(hex0), exp_hex(0));
            check("model_hex1", int'(hex1), exp_hex(1));
            check("model_hex2", int'(hex2), exp_hex(2));
            check("model_hex3", int'(hex3), exp_hex(3));
            check("model_ledr", int'(ledr), m_led ? (1 << LED_W) - 1 : 0);
            check("model_done", int'(done), int'(m_done));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_hex(input string name, input int h3, input int h2,
                             input int h1, input int h0);
        check({name, "_hex3"}, int'(hex3), h3);
        check({name, "_hex2"}, int'(hex2), h2);
        check({name, "_hex1"}, int'(hex1), h1);
        check({name, "_hex0"}, int'(hex0), h0);
    endtask

    task automatic load(input logic [7:0] mm, input logic [7:0] ss);
        state = S_SET_MIN; sw = mm; step(1);
        state = S_SET_SEC; sw = ss; step(1);
    endtask

    initial begin
        rst_n = 1'b0; state = S_RESET; sw = 8'h00;
        step(2);
        rst_n = 1'b1;
        step(1);
        check_hex("reset", 'h40, 'h40, 'h40, 'h40);
        check("reset_ledr", int'(ledr), 0);
        check("reset_done", int'(done), 0);

        state = S_SET_SEC; sw = 8'h47; step(1);
        state = S_SET_MIN; sw = 8'h02; step(1);
        check_hex("load_0247", 'h40, 'h24, 'h19, 'h78);
        state = S_SET_SEC; sw = 8'h7C; step(1);
        check_hex("clamp_0259", 'h40, 'h24, 'h12, 'h10);
        state = S_SETTING_MIN; sw = 8'hF3; step(1);
        check_hex("clamp_9359", 'h10, 'h30, 'h12, 'h10);

        load(8'h01, 8'h00);
        state = S_TIMER; step(3);
        check_hex("timer_c3", 'h40, 'h79, 'h40, 'h40);
        step(1);
        check_hex("timer_c4", 'h40, 'h40, 'h12, 'h10);
        step(4);
        check_hex("timer_c8", 'h40, 'h40, 'h12, 'h00);
        check("timer_c8_done", int'(done), 0);

        load(8'h00, 8'h01);
        state = S_TIMER; step(3);
        check("expire_c3_done", int'(done), 0);
        step(1);
        check("expire_c4_done", int'(done), 1);
        check_hex("expire_c4", 'h40, 'h40, 'h40, 'h40);
        step(8);
        check_hex("expire_hold", 'h40, 'h40, 'h40, 'h40);
        state = S_READY; step(2);
        check("ready_done", int'(done), 1);
        state = S_SET_SEC; sw = 8'h00; step(1);
        check("setsec_done", int'(done), 0);
        state = S_TIMER; step(1);
        check("zero_entry_done", int'(done), 1);

        load(8'h03, 8'h15);
        for (int i = 0; i < 3; i++) begin
            state = S_FON; step(1);
            check("flash_on_ledr", int'(ledr), 'h3FF);
            check_hex("flash_on", 'h40, 'h30, 'h79, 'h12);
            state = S_FOFF; step(1);
            check("flash_off_ledr", int'(ledr), 0);
            check_hex("flash_off", 'h7F, 'h7F, 'h7F, 'h7F);
        end
        state = S_READY; step(1);
        check_hex("after_flash", 'h40, 'h30, 'h79, 'h12);

        load(8'h00, 8'h05);
        state = S_TIMER; step(2);
        state = S_FON; step(3);
        state = S_TIMER; step(1);
        check_hex("presc_hold_a", 'h40, 'h40, 'h40, 'h12);
        step(1);
        check_hex("presc_hold_b", 'h40, 'h40, 'h40, 'h19);

        load(8'h00, 8'h30);
        state = S_TIMER; step(2);
        rst_n = 1'b0; step(1);
        rst_n = 1'b1;
        check_hex("midreset", 'h40, 'h40, 'h40, 'h40);
        check("midreset_done", int'(done), 0);
        step(2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
